// File: rtl/packet_assembler_if.sv
// Data-island packet bus between the packet source/sink and packet_assembler.
interface packet_assembler_if;
  logic         data_island_period;
  logic [23:0]  header;
  logic [223:0] sub;
  logic [8:0]   packet_data;
  logic [4:0]   counter;
  logic         packet_taken;

  modport master (
    output data_island_period, header, sub,
    input  packet_data, counter, packet_taken
  );

  modport slave (
    input  data_island_period, header, sub,
    output packet_data, counter, packet_taken
  );
endinterface

// File: rtl/packet_assembler.sv
// Serialises one HDMI data-island packet into per-pixel TERC4 lane bits,
// appending BCH parity computed on the fly.
module packet_assembler (
  input logic clk_pixel,
  input logic reset,
  packet_assembler_if.slave bus
);

  function automatic logic [7:0] ecc_step(
    input logic [7:0] e,
    input logic       b
  );
    return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
  endfunction

  logic [4:0]   k_q, k_d;
  logic [23:0]  hdr_q;
  logic [223:0] sub_q;
  logic [7:0]   ecc_h_q, ecc_h_d;
  logic [8:0]   pd_q;
  logic [4:0]   cnt_q;
  logic         tkn_q;

  logic         dip, first, cap;
  logic [23:0]  hsrc;
  logic [3:0][55:0] ssrc;
  logic         hbit;
  logic [3:0]   ch1, ch2;

  assign dip   = bus.data_island_period;
  assign first = (k_q == 5'd0);
  assign cap   = dip && first;

  // Capture cycle reads the live inputs so bit 0 matches the shadow.
  assign hsrc = first ? bus.header : hdr_q;
  assign ssrc = first ? bus.sub    : sub_q;

  always_comb begin
    k_d     = dip ? k_q + 5'd1 : 5'd0;
    ecc_h_d = ecc_h_q;
    hbit    = 1'b0;
    if (k_q < 5'd24) begin
      hbit    = hsrc[k_q];
      ecc_h_d = ecc_step(first ? 8'h00 : ecc_h_q, hbit);
    end else begin
      hbit    = ecc_h_q[k_q[2:0]];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sub
    logic [7:0] ecc_q, ecc_d;
    logic       b0, b1;

    always_comb begin
      ecc_d = ecc_q;
      b0    = 1'b0;
      b1    = 1'b0;
      if (k_q < 5'd28) begin
        b0    = ssrc[g][{k_q, 1'b0}];
        b1    = ssrc[g][{k_q, 1'b1}];
        ecc_d = ecc_step(ecc_step(first ? 8'h00 : ecc_q, b0), b1);
      end else begin
        b0    = ecc_q[{k_q[1:0], 1'b0}];
        b1    = ecc_q[{k_q[1:0], 1'b1}];
      end
    end

    assign ch1[g] = b0;
    assign ch2[g] = b1;

    always_ff @(posedge clk_pixel) begin
      if (reset) begin
        ecc_q <= 8'h00;
      end else if (dip) begin
        ecc_q <= ecc_d;
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      k_q     <= 5'd0;
      hdr_q   <= 24'd0;
      sub_q   <= 224'd0;
      ecc_h_q <= 8'h00;
      pd_q    <= 9'd0;
      cnt_q   <= 5'd0;
      tkn_q   <= 1'b0;
    end else begin
      k_q   <= k_d;
      if (dip) ecc_h_q <= ecc_h_d;
      if (cap) begin
        hdr_q <= bus.header;
        sub_q <= bus.sub;
      end
      pd_q  <= dip ? {ch2, ch1, hbit} : 9'd0;
      cnt_q <= dip ? k_q : 5'd0;
      tkn_q <= cap;
    end
  end

  assign bus.packet_data  = pd_q;
  assign bus.counter      = cnt_q;
  assign bus.packet_taken = tkn_q;

endmodule

// File: doc/packet_assembler.md
# packet_assembler

Serialises one HDMI data-island packet (24-bit header plus four 56-bit subpackets) into the per-pixel bit lanes carried on the TMDS channels during a data-island period. It computes the BCH ECC parity bytes on the fly and appends them. It sits directly upstream of the `hdmi` block's data-island path and replaces its hard-wired NULL packet. Its `packet_data` output feeds the TERC4 nibbles:
- channel 0 bit 2
- channel 1 bits [3:0]
- channel 2 bits [3:0]

## Interface
- No parameters; packet geometry is fixed by HDMI 1.3a Section 5.3.
- `clk_pixel  input  1` — pixel clock; all logic on its rising edge.
- `reset  input  1` — synchronous, active-high.
- `data_island_period  input  1` — high for each pixel clock of a data-island period; one packet per 32 consecutive high cycles.
- `header  input  24` — packet header HB0..HB2; bit 0 is sent first.
- `sub  input  224` — subpackets; subpacket n occupies `sub[56n+55:56n]`, bit 0 sent first.
- `packet_data  output  9` — `{ch2[3:0], ch1[3:0], ch0_bit2}` for the current pixel.
- `counter  output  5` — bit index within the packet being emitted.
- `packet_taken  output  1` — one-cycle pulse: header/sub were captured; the source may change them from the next cycle.

## Operation
- **Internal cycle counter `k` (0..31):**
  - Advances by 1 each cycle `data_island_period` is high, wrapping 31→0.
  - Forced to 0 on any cycle it is low.
- **Capture:**
  - On a cycle with `data_island_period`=1 and `k`=0, latch `header` and `sub` into shadow registers.
  - Clear all five ECC accumulators.
  - Assert `packet_taken` the following cycle.
  - The shadow registers alone drive all bit selection for the rest of the packet.
- **ECC accumulator update, one input bit b:**
  - `ecc = (ecc >> 1) ^ ((ecc[0] ^ b) ? 8'h83 : 8'h00)`.
  - This is BCH generator x^8+x^7+x^6+1, LSB-first.
  - Zero data yields zero parity.
- **Header lane (channel 0 bit 2):**
  - `k`=0..23: emit header bit `k` and fold it into the header ECC.
  - `k`=24..31: emit header ECC bit `k-24`, frozen after `k`=23.
- **Subpacket n lanes:**
  - `k`=0..27: ch1 bit n = sub bit 2k and ch2 bit n = sub bit 2k+1.
  - Fold bit 2k first, then 2k+1, into that subpacket's ECC in the same cycle.
  - `k`=28..31: ch1 bit n = ECC bit 2(k-28) and ch2 bit n = ECC bit 2(k-28)+1, ECC frozen after `k`=27.
- On cycle `k`=0 the lanes use the live `header`/`sub` inputs, which are being captured that cycle. This makes the first bits match the shadowed packet.
- **Back-to-back packets:** if `data_island_period` stays high past 32 cycles, `k` wraps. A new capture and `packet_taken` occur, with no idle cycle between packets.
- **Abort:** `data_island_period` falling mid-packet:
  - Returns `k` to 0 and drops the partial packet.
  - No further `packet_taken` is issued.
  - The next rising period starts a fresh capture.
- Outside data-island periods, `packet_data` = 0.

## Timing
- **Reset values:** `packet_data`=0, `counter`=0, `packet_taken`=0, `k`=0, ECC registers=0, shadow registers=0.
- **Reset mid-packet:** identical to abort; the outputs are 0 the cycle after reset is sampled.
- **Latency:** `packet_data`, `counter` and `packet_taken` are registered, one cycle after the `data_island_period` cycle they correspond to. This matches the one-cycle register stage on `hdmi`'s data-island input.
- `counter` equals the `k` of the registered bits, and is 0 when not in a period.
- `packet_taken` is high in the same output cycle as `counter`=0 of a valid packet.
- **Header/sub setup:** values must be stable at the capture edge. Changes at any other time have no effect on the packet in flight.

## Test plan
- **All-zero header and sub, one 32-cycle period:**
  - `packet_data`=0 for all 32 output cycles, including parity.
  - `packet_taken` high exactly once, aligned with `counter`=0.
- **`header`=24'h000001, sub=0:**
  - Ch0 lane reads 1 then 23 zeros.
  - Cycles 24..31 carry ECC 8'h4A LSB-first: 0,1,0,1,0,0,1,0.
  - Ch1/ch2 stay 0.
- **`sub[55:0]`=56'h1, other subpackets 0:**
  - Output cycle 0 shows ch1 bit0=1.
  - Cycles 28..31 carry subpacket-0 parity equal to a software model of the same LFSR.
  - Ch1/ch2 bits [3:1] stay 0.
- **Period held high for 64 cycles, header changed right after `packet_taken`:**
  - Two complete packets, the second carrying the new header.
  - `packet_taken` pulses at output cycles 0 and 32.
  - Counter sequence is 0..31,0..31.
- **Period dropped at `k`=10, re-asserted 5 cycles later:**
  - Outputs go to 0 during the gap.
  - The new packet starts at `counter`=0 with fresh capture and ECC.
  - No stale parity leaks in.
- **`reset` asserted at `k`=15 for one cycle while the period stays high:**
  - All outputs 0 the next cycle.
  - Counting restarts from 0 with a new capture on the first post-reset cycle.
